seq_event_logger: RTL and testbench
===================================

SEQ_EVENT_LOGGER -- requirements
Module: seq_event_logger

Interface
REQ-001 Parameter TS_W, default 16, width of the timestamp counter and of evt_data.
REQ-002 Parameter DEPTH, default 4, number of FIFO entries; SHALL be a power of 2, at least 2.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 det_in  input  1  detection pulse from the upstream serial sequence detector, sampled on every rising clk edge.
REQ-006 clr  input  1  synchronous clear of all logger state.
REQ-007 evt_valid  output  1  FIFO head holds an event.
REQ-008 evt_ready  input  1  consumer accepts the head event.
REQ-009 evt_data  output  TS_W  timestamp of the head event.
REQ-010 evt_count  output  8  total det_in pulses seen, saturating.
REQ-011 overflow  output  1  sticky flag: at least one event was dropped.
REQ-012 fifo_level  output  $clog2(DEPTH)+1  number of occupied FIFO entries.

Function
REQ-013 Timestamp counter ts SHALL increment by 1 every clk cycle and wrap from 2^TS_W-1 to 0.
REQ-014 Push condition: det_in=1 at a rising edge; the pushed value SHALL be ts before that edge's increment.
REQ-015 Pop condition: evt_valid=1 and evt_ready=1 at a rising edge; the head entry SHALL be removed.
REQ-016 evt_valid SHALL be 1 exactly when fifo_level>0; evt_data SHALL equal the head entry when valid, else all zeros.
REQ-017 Latency: an event pushed at edge k SHALL appear on evt_valid/evt_data after edge k, provided the FIFO was empty before edge k.
REQ-018 Event order SHALL be first-in first-out; read and write pointers SHALL wrap modulo DEPTH.
REQ-019 Push when full with no simultaneous pop: event dropped, overflow set to 1, fifo_level unchanged.
REQ-020 Push and pop in the same edge when full: both performed, level stays DEPTH, overflow unchanged.
REQ-021 Push and pop in the same edge at any other non-zero level: both performed, level unchanged.
REQ-022 Pop when empty SHALL NOT be possible, because evt_valid=0; evt_ready is ignored.
REQ-023 evt_count SHALL increment on every det_in=1, including dropped events, and hold at 255.
REQ-024 overflow SHALL remain 1 until clr or reset.
REQ-025 evt_valid, evt_data and fifo_level SHALL be driven from registers or from registered state only, with no combinational path from det_in.
REQ-026 Once evt_valid=1 it SHALL stay 1, with evt_data stable, until popped.
REQ-027 clr=1 at an edge SHALL:
  - empty the FIFO;
  - set ts, evt_count and overflow to 0;
  - take priority over det_in and evt_ready in that cycle, so that det_in is neither pushed nor counted.
REQ-028 Back-to-back det_in on consecutive cycles SHALL each be logged, with distinct consecutive timestamps.

Reset
REQ-029 rst=0 SHALL immediately force, independent of clk:
  - ts=0, pointers=0, fifo_level=0;
  - evt_valid=0, evt_data=0;
  - evt_count=0, overflow=0.
REQ-030 FIFO storage contents need not be reset.
REQ-031 Reset asserted mid-operation SHALL discard all pending events.
REQ-032 The first ts increment SHALL occur on the first rising edge after rst deasserts.

Verification
REQ-033 After reset, det_in pulses at ts=5 and ts=12 with evt_ready=0 -> fifo_level=2, evt_data=5; raising evt_ready gives evt_data=12 after one edge, then evt_valid=0.
REQ-034 DEPTH=4, evt_ready=0, 6 det_in pulses -> fifo_level=4, overflow=1, evt_count=6, drained data equals the first 4 timestamps in order.
REQ-035 Full FIFO with det_in=1 and evt_ready=1 in the same edge -> level stays 4, overflow=0, new timestamp at the tail.
REQ-036 300 det_in pulses -> evt_count holds at 255.
REQ-037 ts near 0xFFFE with pulses on 3 consecutive cycles -> logged values 0xFFFE, 0xFFFF, 0x0000.
REQ-038 clr=1 coincident with det_in=1 at level 3 -> level 0, evt_count 0, overflow 0, no event logged; likewise rst=0 mid-drain -> all outputs 0 immediately.

Source files
------------

// File: rtl/seq_event_logger.sv
// -----------------------------------------------------------------------------
// seq_event_logger
//
// Timestamps detection pulses from an upstream serial sequence detector and
// queues the timestamps in a small FIFO for a downstream consumer.
//
// Ports
//   clk        in   1               rising-edge clock for all state
//   rst        in   1               asynchronous, active-low reset
//   det_in     in   1               detection pulse, sampled every rising edge
//   clr        in   1               synchronous clear of all logger state
//   evt_valid  out  1               FIFO head holds an event
//   evt_ready  in   1               consumer accepts the head event
//   evt_data   out  TS_W            timestamp of the head event (0 when empty)
//   evt_count  out  8               total det_in pulses seen, saturating at 255
//   overflow   out  1               sticky: at least one event was dropped
//   fifo_level out  $clog2(DEPTH)+1 number of occupied FIFO entries
//
// Handshake: an event transfers on a rising edge where evt_valid=1 and
// evt_ready=1. evt_valid never depends on evt_ready; once raised it stays high
// with evt_data stable until the transfer. evt_ready is ignored while empty.
// -----------------------------------------------------------------------------
module seq_event_logger #(
  parameter int TS_W  = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       det_in,
  input  logic                       clr,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [TS_W-1:0]            evt_data,
  output logic [7:0]                 evt_count,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     fifo_level
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  localparam logic [AW-1:0]    PTR_ONE = AW'(1);
  localparam logic [LVL_W-1:0] LVL_ONE = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(DEPTH);
  localparam logic [TS_W-1:0]  TS_ONE  = TS_W'(1);

  // Registered state
  logic [TS_W-1:0]  ts_q,     ts_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q,  level_d;
  logic [7:0]       cnt_q,    cnt_d;
  logic             ovf_q,    ovf_d;
  logic [TS_W-1:0]  mem_q [DEPTH];

  // Transfer qualifiers; clr overrides both push and pop in its cycle.
  logic push, pop, full, wr_en;

  always_comb begin
    full  = (level_q == LVL_MAX);
    push  = det_in & ~clr;
    pop   = (level_q != '0) & evt_ready & ~clr;
    // A full FIFO only accepts a new entry when the head leaves in the same edge.
    wr_en = push & (~full | pop);
  end

  // Next-state logic
  always_comb begin
    ts_d     = ts_q + TS_ONE;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;

    if (clr) begin
      ts_d     = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)   rd_ptr_d = rd_ptr_q + PTR_ONE;

      if (wr_en && !pop)      level_d = level_q + LVL_ONE;
      else if (pop && !wr_en) level_d = level_q - LVL_ONE;

      // Every pulse is counted, including ones that end up dropped.
      if (push && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;

      if (push && !wr_en) ovf_d = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      ts_q     <= ts_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is not reset; the level/pointers alone define what is valid.
  // The stored value is ts before this edge's increment.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= ts_q;
  end

  // Outputs come only from registered state, never from det_in.
  always_comb begin
    evt_valid  = (level_q != '0);
    evt_data   = evt_valid ? mem_q[rd_ptr_q] : '0;
    evt_count  = cnt_q;
    overflow   = ovf_q;
    fifo_level = level_q;
  end

endmodule

// File: tb/tb_seq_event_logger.sv
// -----------------------------------------------------------------------------
// tb_seq_event_logger
//
// Self-checking bench for seq_event_logger: a fixed vector table, hand-written
// corner sequences and a randomized run, all compared against a queue-based
// model of the logger's rules.
// -----------------------------------------------------------------------------
module tb_seq_event_logger;

  localparam int TS_W  = 16;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic            det_in    = 1'b0;
  logic            clr       = 1'b0;
  logic            evt_ready = 1'b0;
  logic            evt_valid;
  logic [TS_W-1:0] evt_data;
  logic [7:0]      evt_count;
  logic            overflow;
  logic [LW-1:0]   fifo_level;

  seq_event_logger #(.TS_W(TS_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .det_in     (det_in),
    .clr        (clr),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_data   (evt_data),
    .evt_count  (evt_count),
    .overflow   (overflow),
    .fifo_level (fifo_level)
  );

  // ---------------- scoreboard / reference model ----------------
  logic [TS_W-1:0] exp_q[$];
  int m_ts;
  int m_cnt;
  bit m_ovf;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ts  = 0;
    m_cnt = 0;
    m_ovf = 0;
  endtask

  // Applies the logger rules to the inputs present at the coming edge.
  task automatic model_edge();
    if (clr) begin
      model_reset();
    end else begin
      bit do_pop;
      do_pop = (exp_q.size() > 0) && evt_ready;
      if (det_in && m_cnt < 255) m_cnt++;
      if (do_pop) void'(exp_q.pop_front());
      if (det_in) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(m_ts[TS_W-1:0]);
        else m_ovf = 1;
      end
      m_ts = (m_ts + 1) % (1 << TS_W);
    end
  endtask

  // One clock: model update, edge, then settle away from the edge.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    det_in = 0; evt_ready = 0; clr = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_model(input string tag);
    logic [TS_W-1:0] head;
    head = (exp_q.size() > 0) ? exp_q[0] : '0;
    chk({tag, ".valid"}, evt_valid, exp_q.size() > 0);
    chk({tag, ".data"},  evt_data, head);
    chk({tag, ".level"}, fifo_level, exp_q.size());
    chk({tag, ".count"}, evt_count, m_cnt);
    chk({tag, ".ovf"},   overflow, m_ovf);
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    det_in = 0; evt_ready = 0; clr = 0;
    @(negedge clk);
    rst = 0;
    #1;
    model_reset();
    check_model("reset");
    @(posedge clk);
    #1;
    rst = 1;
  endtask

  task automatic pulse_det(input int n);
    det_in = 1; evt_ready = 0; clr = 0;
    for (int i = 0; i < n; i++) step();
    det_in = 0;
  endtask

  // Pops one event and checks it matched the required timestamp.
  task automatic drain_one(input string name, input logic [TS_W-1:0] exp_ts);
    chk({name, ".head"}, evt_data, exp_ts);
    det_in = 0; evt_ready = 1; clr = 0;
    step();
    evt_ready = 0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic det;
    logic rdy;
    logic clr;
    int   lvl;
    logic vld;
    int   data;
    int   cnt;
    logic ovf;
  } vec_t;

  vec_t vecs[12];

  initial begin
    // inputs (det, rdy, clr) -> outputs after the edge; starts at ts=0
    vecs[0]  = '{1, 0, 0, 1, 1, 0, 1, 0};   // push ts0
    vecs[1]  = '{1, 0, 0, 2, 1, 0, 2, 0};   // push ts1
    vecs[2]  = '{0, 1, 0, 1, 1, 1, 2, 0};   // pop 0
    vecs[3]  = '{1, 1, 0, 1, 1, 3, 3, 0};   // pop 1, push ts3
    vecs[4]  = '{1, 0, 0, 2, 1, 3, 4, 0};
    vecs[5]  = '{1, 0, 0, 3, 1, 3, 5, 0};
    vecs[6]  = '{1, 0, 0, 4, 1, 3, 6, 0};   // full
    vecs[7]  = '{1, 0, 0, 4, 1, 3, 7, 1};   // ts7 dropped
    vecs[8]  = '{1, 1, 0, 4, 1, 4, 8, 1};   // full push+pop
    vecs[9]  = '{1, 1, 1, 0, 0, 0, 0, 0};   // clr wins
    vecs[10] = '{0, 1, 0, 0, 0, 0, 0, 0};   // ready while empty ignored
    vecs[11] = '{1, 1, 0, 1, 1, 1, 1, 0};   // push ts1 into empty

    apply_reset();

    // ---- table-driven vectors ----
    for (int i = 0; i < 12; i++) begin
      det_in = vecs[i].det; evt_ready = vecs[i].rdy; clr = vecs[i].clr;
      step();
      chk($sformatf("vec%0d.level", i), fifo_level, vecs[i].lvl);
      chk($sformatf("vec%0d.valid", i), evt_valid, vecs[i].vld);
      chk($sformatf("vec%0d.data", i),  evt_data, vecs[i].data);
      chk($sformatf("vec%0d.count", i), evt_count, vecs[i].cnt);
      chk($sformatf("vec%0d.ovf", i),   overflow, vecs[i].ovf);
    end
    idle(1);

    // ---- pulses at ts=5 and ts=12, then drain ----
    apply_reset();
    idle(5);
    pulse_det(1);          // ts5
    idle(6);
    pulse_det(1);          // ts12
    chk("two.level", fifo_level, 2);
    chk("two.data", evt_data, 5);
    evt_ready = 1;
    step();
    chk("two.data2", evt_data, 12);
    chk("two.valid2", evt_valid, 1);
    step();
    chk("two.valid_end", evt_valid, 0);
    evt_ready = 0;

    // ---- six pulses into a depth-4 FIFO ----
    apply_reset();
    pulse_det(6);          // ts0..5
    chk("ovf6.level", fifo_level, 4);
    chk("ovf6.ovf", overflow, 1);
    chk("ovf6.count", evt_count, 6);
    for (int i = 0; i < 4; i++) drain_one($sformatf("ovf6.drain%0d", i), TS_W'(i));
    chk("ovf6.empty", evt_valid, 0);

    // ---- full with simultaneous push and pop ----
    apply_reset();
    pulse_det(4);          // ts0..3
    det_in = 1; evt_ready = 1;
    step();                // ts4 pushed, 0 popped
    det_in = 0; evt_ready = 0;
    chk("fullpp.level", fifo_level, 4);
    chk("fullpp.ovf", overflow, 0);
    for (int i = 1; i <= 4; i++) drain_one($sformatf("fullpp.drain%0d", i), TS_W'(i));
    check_model("fullpp.end");

    // ---- counter saturation ----
    apply_reset();
    det_in = 1; evt_ready = 1;
    for (int i = 0; i < 300; i++) step();
    det_in = 0; evt_ready = 0;
    chk("sat.count", evt_count, 255);
    check_model("sat");

    // ---- timestamp wrap ----
    apply_reset();
    idle(65534);
    pulse_det(3);
    drain_one("wrap0", 16'hFFFE);
    drain_one("wrap1", 16'hFFFF);
    drain_one("wrap2", 16'h0000);

    // ---- clr coincident with det at level 3 ----
    apply_reset();
    pulse_det(3);
    chk("clr.pre_level", fifo_level, 3);
    det_in = 1; clr = 1;
    step();
    det_in = 0; clr = 0;
    chk("clr.level", fifo_level, 0);
    chk("clr.count", evt_count, 0);
    chk("clr.ovf", overflow, 0);
    chk("clr.valid", evt_valid, 0);
    step();
    chk("clr.no_log", fifo_level, 0);

    // ---- asynchronous reset mid-drain ----
    pulse_det(2);
    evt_ready = 1;
    step();
    #3;
    rst = 0;               // between edges
    #1;
    chk("arst.valid", evt_valid, 0);
    chk("arst.data", evt_data, 0);
    chk("arst.level", fifo_level, 0);
    chk("arst.count", evt_count, 0);
    chk("arst.ovf", overflow, 0);
    model_reset();
    evt_ready = 0;
    @(posedge clk);
    #1;
    rst = 1;
    step();
    check_model("arst.after");

    // ---- randomized run against the model ----
    for (int i = 0; i < 2000; i++) begin
      det_in    = $urandom_range(0, 1);
      evt_ready = (i < 1000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      clr       = ($urandom_range(0, 63) == 0);
      step();
      check_model("rand");
    end
    idle(2);
    check_model("rand.end");

    // ---- report ----
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
